// File: rtl/fir_decim.sv
// Decimating FIR filter between two FIFOs.
// Collects DECIM samples into a NUM_TAPS-deep history, then spends
// NUM_TAPS cycles on a serial multiply-accumulate (one tap per cycle).
// It then holds the result until the downstream FIFO accepts it.
module fir_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 32,
  parameter int DECIM      = 8,
  parameter int BITS       = 10,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: '0}
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] dout,
  input  logic                         out_full,
  output logic                         out_wr_en
);

  localparam int TW     = $clog2(NUM_TAPS);
  localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  // Added to negative products before the shift so the shift truncates toward zero
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'((64'sd1 <<< BITS) - 64'sd1);
  localparam logic signed [PROD_W-1:0] ZERO_P     = '0;

  typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   hist_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]   hist_d [NUM_TAPS];
  logic [PW-1:0]                  phase_q;
  logic [TW-1:0]                  tap_q;
  logic signed [DATA_WIDTH-1:0]   acc_q;
  logic signed [DATA_WIDTH-1:0]   dout_q;

  logic                           group_done;
  logic                           last_tap;
  logic signed [DATA_WIDTH-1:0]   coef_sel, samp_sel;
  logic signed [PROD_W-1:0]       coef_ext, samp_ext, prod, bias, prod_adj;
  logic signed [DATA_WIDTH-1:0]   term, acc_sum;

  assign group_done = in_rd_en && (phase_q == PW'(DECIM - 1));
  assign last_tap   = (tap_q == TW'(NUM_TAPS - 1));

  // Shifted history: x[n] sits at index 0, older samples at higher indices
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_d[gi] = din;
      end else begin : g_body
        assign hist_d[gi] = hist_q[gi-1];
      end
    end
  endgenerate

  // One tap product, dequantized with truncation toward zero
  always_comb begin
    coef_sel = COEFFS[tap_q];
    samp_sel = hist_q[tap_q];
    coef_ext = {{DATA_WIDTH{coef_sel[DATA_WIDTH-1]}}, coef_sel};
    samp_ext = {{DATA_WIDTH{samp_sel[DATA_WIDTH-1]}}, samp_sel};
    prod     = coef_ext * samp_ext;
    bias     = prod[PROD_W-1] ? ROUND_BIAS : ZERO_P;
    prod_adj = prod + bias;
    term     = DATA_WIDTH'(prod_adj >>> BITS);
    acc_sum  = acc_q + term;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_READ;
    else       state_q <= state_d;
  end

  // FSM next state and FIFO handshakes; reads stay off while reset is held
  always_comb begin
    state_d   = state_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_READ: begin
        in_rd_en = !in_empty && !reset;
        if (group_done) state_d = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_d = S_WRITE;
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (!out_full) state_d = S_READ;
      end
      default: state_d = S_READ;
    endcase
  end

  // Datapath: history, phase counter, tap counter, accumulator, held output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      phase_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        S_READ: begin
          if (in_rd_en) begin
            hist_q  <= hist_d;
            phase_q <= group_done ? '0 : phase_q + 1'b1;
          end
          if (group_done) begin
            acc_q <= '0;
            tap_q <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_sum;
          tap_q <= tap_q + 1'b1;
          if (last_tap) dout_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: three instances with ramp, DC and unit coefficient sets.
// These are checked each cycle against a sum-of-products model, with literal pins
module tb_fir_decim;

  localparam int NT  = 32;
  localparam int DM  = 8;
  localparam int LAT = NT + 1;

  localparam logic signed [31:0] H_RAMP [NT] = '{ 1,  2,  3,  4,  5,  6,  7,  8,
                                                  9, 10, 11, 12, 13, 14, 15, 16,
                                                 17, 18, 19, 20, 21, 22, 23, 24,
                                                 25, 26, 27, 28, 29, 30, 31, 32};
  localparam logic signed [31:0] H_DC   [NT] = '{default: 32};
  localparam logic signed [31:0] H_ONE  [NT] = '{0: 1, default: 0};

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic signed [31:0] din_s [3];
  logic               in_empty_s [3];
  logic               in_rd_en_s [3];
  logic signed [31:0] dout_s [3];
  logic               out_full_s [3];
  logic               out_wr_en_s [3];

  fir_decim #(.COEFFS(H_RAMP)) u_ramp (
    .clock(clock), .reset(reset), .din(din_s[0]), .in_empty(in_empty_s[0]),
    .in_rd_en(in_rd_en_s[0]), .dout(dout_s[0]), .out_full(out_full_s[0]),
    .out_wr_en(out_wr_en_s[0]));
  fir_decim #(.COEFFS(H_DC)) u_dc (
    .clock(clock), .reset(reset), .din(din_s[1]), .in_empty(in_empty_s[1]),
    .in_rd_en(in_rd_en_s[1]), .dout(dout_s[1]), .out_full(out_full_s[1]),
    .out_wr_en(out_wr_en_s[1]));
  fir_decim #(.COEFFS(H_ONE)) u_one (
    .clock(clock), .reset(reset), .din(din_s[2]), .in_empty(in_empty_s[2]),
    .in_rd_en(in_rd_en_s[2]), .dout(dout_s[2]), .out_full(out_full_s[2]),
    .out_wr_en(out_wr_en_s[2]));

  int total = 0;
  int bad   = 0;

  // Stimulus sources and knobs
  int src [3][$];
  bit take [3];
  bit stall_en [3];
  bit full_rand [3];
  bit full_force [3];

  // Behavioural model state
  int                 coef [3][NT];
  logic signed [31:0] mh [3][NT];
  int                 mphase [3];
  bit                 pend [3];
  int                 age [3];
  logic signed [31:0] expv [3];
  logic signed [31:0] got [3][$];

  // y = sum_k trunc32(trunc_toward_zero(h[k]*x[n-k] / 1024)), wrapping at 32 bits
  function automatic logic signed [31:0] model_y(int i);
    logic signed [31:0] s;
    longint p;
    s = 0;
    for (int k = 0; k < NT; k++) begin
      p = longint'(coef[i][k]) * longint'(mh[i][k]);
      s = s + 32'(p / 64'sd1024);
    end
    return s;
  endfunction

  // Compare process: handshake rules, latency, output value, model update
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (in_rd_en_s[i] !== 1'b0 || out_wr_en_s[i] !== 1'b0 || dout_s[i] !== 32'sd0) begin
          bad++;
          $display("FAIL reset_state dut%0d: rd=%b wr=%b dout=%0d, required rd=0 wr=0 dout=0",
                   i, in_rd_en_s[i], out_wr_en_s[i], dout_s[i]);
        end
        for (int k = 0; k < NT; k++) mh[i][k] = 0;
        mphase[i] = 0;
        pend[i]   = 0;
        age[i]    = 0;
        take[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic exp_rd, exp_wr;
        if (pend[i]) age[i]++;
        exp_rd = !in_empty_s[i] && !pend[i];
        exp_wr = pend[i] && (age[i] >= LAT) && !out_full_s[i];
        total++;
        if (in_rd_en_s[i] !== exp_rd) begin
          bad++;
          $display("FAIL rd_en dut%0d: got %b, required %b (empty=%b pending=%0d)",
                   i, in_rd_en_s[i], exp_rd, in_empty_s[i], pend[i]);
        end
        total++;
        if (out_wr_en_s[i] !== exp_wr) begin
          bad++;
          $display("FAIL wr_en dut%0d: got %b, required %b (age=%0d full=%b)",
                   i, out_wr_en_s[i], exp_wr, age[i], out_full_s[i]);
        end
        if (pend[i] && age[i] >= LAT) begin
          total++;
          if (dout_s[i] !== expv[i]) begin
            bad++;
            $display("FAIL dout dut%0d: got %0d, required %0d", i, dout_s[i], expv[i]);
          end
          if (out_wr_en_s[i]) begin
            $display("push dut%0d: dout=%0d", i, dout_s[i]);
            got[i].push_back(dout_s[i]);
            pend[i] = 0;
          end
        end
        take[i] = in_rd_en_s[i];
        if (in_rd_en_s[i] && !pend[i]) begin
          for (int k = NT - 1; k > 0; k--) mh[i][k] = mh[i][k-1];
          mh[i][0] = din_s[i];
          mphase[i]++;
          if (mphase[i] == DM) begin
            mphase[i] = 0;
            expv[i]   = model_y(i);
            pend[i]   = 1;
            age[i]    = 0;
          end
        end
      end
    end
  end

  // Source driver: pops consumed samples, applies optional stalls and backpressure
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (take[i]) begin
          if (src[i].size() > 0) void'(src[i].pop_front());
          take[i] = 0;
        end
        if (src[i].size() > 0 && !(stall_en[i] && $urandom_range(0, 1) == 0)) begin
          in_empty_s[i] = 1'b0;
          din_s[i]      = src[i][0];
        end else begin
          in_empty_s[i] = 1'b1;
          din_s[i]      = $urandom;
        end
        out_full_s[i] = full_force[i] || (full_rand[i] && $urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) src[i].delete();
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic wait_out(input int i, input int n, input int lim, input string tag);
    int c;
    c = 0;
    while (got[i].size() < n && c < lim) begin
      @(posedge clock);
      c++;
    end
    total++;
    if (got[i].size() < n) begin
      bad++;
      $display("FAIL %s timeout dut%0d: got %0d outputs, required %0d", tag, i, got[i].size(), n);
    end
  endtask

  task automatic check_got(input int i, input int idx, input int req, input string tag);
    total++;
    if (got[i].size() <= idx) begin
      bad++;
      $display("FAIL %s[%0d]: no output, required %0d", tag, idx, req);
    end else if (got[i][idx] !== 32'(req)) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d, required %0d", tag, idx, got[i][idx], req);
    end
  endtask

  task automatic load_impulse();
    src[0].push_back(1024);
    for (int k = 1; k < 32; k++) src[0].push_back(0);
  endtask

  int dc_exp [8] = '{256, 512, 768, 1024, 1024, 1024, 1024, 1024};
  int rnd_exp [3] = '{0, -1, 1};
  int rnd_in  [3] = '{-1023, -1025, 1025};

  initial begin
    int c;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_s[i] = 0; in_empty_s[i] = 1'b1; out_full_s[i] = 1'b0;
      stall_en[i] = 0; full_rand[i] = 0; full_force[i] = 0; take[i] = 0;
      for (int k = 0; k < NT; k++) begin
        mh[i][k] = 0;
      end
    end
    for (int k = 0; k < NT; k++) begin
      coef[0][k] = H_RAMP[k];
      coef[1][k] = H_DC[k];
      coef[2][k] = H_ONE[k];
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Impulse through ramp coefficients
    load_impulse();
    wait_out(0, 4, 600, "impulse");
    for (int k = 0; k < 4; k++) check_got(0, k, 8 * (k + 1), "impulse");
    got[0].delete();

    // DC response, first without and then with input stalls
    for (int pass = 0; pass < 2; pass++) begin
      stall_en[1] = (pass == 1);
      for (int k = 0; k < 64; k++) src[1].push_back(1024);
      wait_out(1, 8, 4000, pass == 0 ? "dc" : "dc_stall");
      for (int k = 0; k < 8; k++) check_got(1, k, dc_exp[k], pass == 0 ? "dc" : "dc_stall");
      got[1].delete();
      if (pass == 0) do_reset();
    end
    stall_en[1] = 0;

    // Truncation toward zero at the fractional boundary
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 7; k++) src[2].push_back(0);
      src[2].push_back(rnd_in[g]);
    end
    wait_out(2, 3, 800, "round");
    for (int k = 0; k < 3; k++) check_got(2, k, rnd_exp[k], "round");
    got[2].delete();

    // Backpressure: history is all 1024 after the DC runs, so the result is 1024
    full_force[1] = 1;
    for (int k = 0; k < 8; k++) src[1].push_back(1024);
    c = 0;
    while (!(pend[1] && age[1] >= LAT + 20) && c < 300) begin
      @(posedge clock);
      c++;
    end
    total++;
    if (!(pend[1] && age[1] >= LAT + 20)) begin
      bad++;
      $display("FAIL backpressure_hold: pending=%0d age=%0d, required pending with age>=%0d",
               pend[1], age[1], LAT + 20);
    end
    full_force[1] = 0;
    wait_out(1, 1, 10, "backpressure");
    check_got(1, 0, 1024, "backpressure");
    got[1].delete();

    // Random data, stalls and backpressure on the ramp and unit filters
    stall_en[0] = 1; full_rand[0] = 1;
    stall_en[2] = 1; full_rand[2] = 1;
    for (int k = 0; k < 160; k++) src[0].push_back(int'($urandom));
    for (int k = 0; k < 80; k++)  src[2].push_back(int'($urandom_range(0, 4095)) - 2048);
    wait_out(0, 20, 20000, "random_ramp");
    wait_out(2, 10, 20000, "random_one");
    stall_en[0] = 0; full_rand[0] = 0;
    stall_en[2] = 0; full_rand[2] = 0;
    repeat (4) @(posedge clock);
    got[0].delete();
    got[2].delete();

    // Reset in the middle of the second group's MAC: that output must vanish
    do_reset();
    for (int k = 0; k < 16; k++) src[0].push_back(1000 + k);
    c = 0;
    while (!(got[0].size() == 1 && pend[0] && age[0] >= 10) && c < 400) begin
      @(posedge clock);
      c++;
    end
    total++;
    if (!(got[0].size() == 1 && pend[0])) begin
      bad++;
      $display("FAIL reset_mac_setup: outputs=%0d pending=%0d, required 1 and 1", got[0].size(), pend[0]);
    end
    do_reset();
    repeat (80) @(posedge clock);
    total++;
    if (got[0].size() != 1) begin
      bad++;
      $display("FAIL reset_discard: outputs=%0d, required 1", got[0].size());
    end
    got[0].delete();
    load_impulse();
    wait_out(0, 4, 600, "impulse_after_reset");
    for (int k = 0; k < 4; k++) check_got(0, k, 8 * (k + 1), "impulse_after_reset");

    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001: Parameter DATA_WIDTH, 32, sample and coefficient width (signed two's complement).
REQ-002: Parameter NUM_TAPS, 32, filter length; power of two, 8..64.
REQ-003: Parameter DECIM, 8, decimation factor; power of two, 1..NUM_TAPS.
REQ-004: Parameter BITS, 10, fixed-point fraction bits; quantization scale is 2^BITS (1024).
REQ-005: Parameter COEFFS, all-zero, NUM_TAPS x DATA_WIDTH signed coefficient array h[0..NUM_TAPS-1], quantized at 2^BITS.
REQ-006: clock  input  1  rising-edge system clock.
REQ-007: reset  input  1  asynchronous, active-high reset.
REQ-008: din  input  DATA_WIDTH  signed input sample from upstream FIFO, valid in the cycle in_rd_en is high.
REQ-009: in_empty  input  1  upstream FIFO empty.
REQ-010: in_rd_en  output  1  upstream FIFO pop; din consumed this cycle.
REQ-011: dout  output  DATA_WIDTH  signed filtered, decimated sample to the downstream de-emphasis IIR FIFO.
REQ-012: out_full  input  1  downstream FIFO full.
REQ-013: out_wr_en  output  1  downstream FIFO push of dout this cycle.

Function
REQ-014: FSM states: S_READ, S_MAC, S_WRITE.
REQ-015: S_READ: in_rd_en = !in_empty (combinational); on each pop, din shifts into the history buffer (x[n] newest; oldest discarded) and the phase counter increments.
REQ-016: When the pop makes the phase counter reach DECIM, the counter returns to 0 and the next state is S_MAC; otherwise remain in S_READ.
REQ-017: in_rd_en is 0 in S_MAC and S_WRITE; no input is consumed while computing or writing.
REQ-018: S_MAC: one tap per cycle, k = 0..NUM_TAPS-1, acc += DEQ(h[k] * x[n-k]); exactly NUM_TAPS cycles, then S_WRITE.
REQ-019: Product: full 2*DATA_WIDTH signed; DEQ = signed divide by 2^BITS, truncating toward zero (not arithmetic shift), result truncated to DATA_WIDTH.
REQ-020: Accumulator: DATA_WIDTH signed, wraps modulo 2^DATA_WIDTH; no saturation; cleared on entry to S_MAC.
REQ-021: S_WRITE: dout = acc; out_wr_en = !out_full; on push, next state S_READ; while out_full, hold S_WRITE and dout stable.
REQ-022: out_wr_en is 0 outside S_WRITE; exactly one push per DECIM accepted inputs.
REQ-023: History positions never written since reset read as 0.
REQ-024: Latency: the DECIM-th pop at cycle t gives out_wr_en at cycle t+NUM_TAPS+1 when out_full=0.
REQ-025: in_empty asserted mid-group: stall in S_READ with history and phase counter held; no bubble affects results.
REQ-026: Output for group ending at input n: y = sum over k of DEQ(h[k]*x[n-k]), independent of stall pattern.

Reset
REQ-027: reset asserted (any state, including mid-MAC or mid-write) asynchronously forces S_READ, history = 0, phase counter = 0, acc = 0, dout = 0, out_wr_en = 0, in_rd_en reflects !in_empty only after release.
REQ-028: A partial group or pending output at reset is discarded; nothing is pushed for it after release.

Verification
REQ-029: Impulse: COEFFS h[k]=k+1, din 1024 then 31 zeros, no stalls -> 4 outputs: 8, 16, 24, 32 (h[7], h[15], h[23], h[31]).
REQ-030: DC: all h[k]=32, 64 inputs of 1024 -> outputs 256, 512, 768, 1024, 1024, 1024, 1024, 1024.
REQ-031: Rounding: h[0]=1, others 0, DECIM group ending in din=-1023 -> dout 0; din=-1025 -> dout -1; din=1025 -> dout 1.
REQ-032: Backpressure: out_full held high 20 cycles in S_WRITE -> out_wr_en 0, dout stable, in_rd_en 0; first cycle out_full=0 -> single push, return to S_READ.
REQ-033: Random in_empty (50%) with DC stimulus of REQ-030 -> identical output sequence; exactly one push per 8 pops.
REQ-034: Reset during S_MAC of second group -> no push for that group; after release, impulse test of REQ-029 reproduces 8, 16, 24, 32.
